// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider.
//   - Default divider width and reset half-period.
//   - Channel state encoding.
//   - Half-period constants for common output rates from a 100 MHz board clock.
package clk_div_pkg;

    localparam int unsigned DEF_DIV_W = 8;
    localparam int unsigned DEF_HALF  = 49;

    // Half-period minus one for a 100 MHz source: f_out = 100 MHz / (2 * (half + 1)).
    localparam int unsigned HALF_1MHZ  = 49;
    localparam int unsigned HALF_2MHZ  = 24;
    localparam int unsigned HALF_5MHZ  = 9;
    localparam int unsigned HALF_10MHZ = 4;
    localparam int unsigned HALF_25MHZ = 1;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StIdle  = 2'd2
    } ch_state_e;

endpackage

// File: rtl/clk_div_ch.sv
// Single divider channel.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   ch_en_i        : run enable
//   load_i         : capture div_val_i as the pending half-period
//   div_val_i      : requested half-period minus one
//   restart_i      : phase-align strobe (highest priority)
//   clk_o          : 50% duty divided level
//   tick_rise_o    : one-cycle pulse on the first high cycle of clk_o
//   tick_fall_o    : one-cycle pulse on the first low cycle of clk_o
//   pend_o         : a loaded half-period is waiting to be applied
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W        = DEF_DIV_W,
    parameter int unsigned DEFAULT_HALF = DEF_HALF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ch_en_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_val_i,
    input  logic             restart_i,
    output logic             clk_o,
    output logic             tick_rise_o,
    output logic             tick_fall_o,
    output logic             pend_o
);

    ch_state_e        st_q, st_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] half_q, half_d;
    logic [DIV_W-1:0] pend_val_q, pend_val_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             apply;

    always_comb begin
        st_d       = st_q;
        cnt_d      = cnt_q;
        half_d     = half_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        clk_d      = clk_q;
        apply      = 1'b0;

        if (restart_i) begin
            cnt_d = '0;
            clk_d = 1'b0;
            apply = pend_q;
            st_d  = (st_q != StDrain && ch_en_i) ? StRun : StIdle;
        end else begin
            unique case (st_q)
                StRun: begin
                    if (ch_en_i || clk_q) begin
                        if (cnt_q == half_q) begin
                            cnt_d = '0;
                            clk_d = ~clk_q;
                            // New ratio only takes effect on a rising edge so each
                            // full period uses one ratio.
                            apply = pend_q & ~clk_q;
                            // Disabled mid-high and the high phase just ended.
                            if (!ch_en_i) begin
                                st_d = StIdle;
                            end
                        end else begin
                            cnt_d = cnt_q + DIV_W'(1);
                            if (!ch_en_i) begin
                                st_d = StDrain;
                            end
                        end
                    end else begin
                        // Disabled while low: stop at once, nothing to finish.
                        cnt_d = '0;
                        st_d  = StIdle;
                    end
                end
                StDrain: begin
                    // ch_en is ignored until the high phase completes.
                    if (cnt_q == half_q) begin
                        cnt_d = '0;
                        clk_d = 1'b0;
                        st_d  = StIdle;
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
                StIdle: begin
                    cnt_d = '0;
                    clk_d = 1'b0;
                    apply = pend_q;
                    if (ch_en_i) begin
                        st_d = StRun;
                    end
                end
                default: begin
                    cnt_d = '0;
                    clk_d = 1'b0;
                    st_d  = StIdle;
                end
            endcase
        end

        if (apply) begin
            half_d = pend_val_q;
            pend_d = 1'b0;
        end
        // A load in the apply cycle queues the new value behind the applied one.
        if (load_i) begin
            pend_val_d = div_val_i;
            pend_d     = 1'b1;
        end

        rise_d = clk_d & ~clk_q;
        fall_d = ~clk_d & clk_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q       <= StIdle;
            cnt_q      <= '0;
            half_q     <= DIV_W'(DEFAULT_HALF);
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            clk_q      <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            half_q     <= half_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            clk_q      <= clk_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
        end
    end

    assign clk_o       = clk_q;
    assign tick_rise_o = rise_q;
    assign tick_fall_o = fall_q;
    assign pend_o      = pend_q;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider / enable generator.
//   clk_from_FPGA  : board clock, the only clock
//   rst_from_FPGA  : asynchronous active-low reset
//   div_val        : per-channel half-period minus one, channel i at [i*DIV_W +: DIV_W]
//   div_load       : per-channel strobe capturing its div_val slice as pending
//   ch_en          : per-channel run enable
//   sync_restart   : one-cycle strobe phase-aligning all channels
//   clk_out        : divided level outputs
//   tick_rise      : one-cycle pulse on the first high cycle of clk_out
//   tick_fall      : one-cycle pulse on the first low cycle of clk_out
//   pend           : a loaded value is waiting to be applied
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned DIV_W        = DEF_DIV_W,
    parameter int unsigned DEFAULT_HALF = DEF_HALF
) (
    input  logic                    clk_from_FPGA,
    input  logic                    rst_from_FPGA,
    input  logic [NUM_CH*DIV_W-1:0] div_val,
    input  logic [NUM_CH-1:0]       div_load,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    sync_restart,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick_rise,
    output logic [NUM_CH-1:0]       tick_fall,
    output logic [NUM_CH-1:0]       pend
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_ch #(
            .DIV_W       (DIV_W),
            .DEFAULT_HALF(DEFAULT_HALF)
        ) u_ch (
            .clk_i      (clk_from_FPGA),
            .rst_ni     (rst_from_FPGA),
            .ch_en_i    (ch_en[i]),
            .load_i     (div_load[i]),
            .div_val_i  (div_val[i*DIV_W +: DIV_W]),
            .restart_i  (sync_restart),
            .clk_o      (clk_out[i]),
            .tick_rise_o(tick_rise[i]),
            .tick_fall_o(tick_fall[i]),
            .pend_o     (pend[i])
        );
    end

endmodule
